jam_cost_table: RTL and testbench

- Responder end of the worker/job cost-lookup interface. Holds the 8x8 assignment cost matrix and answers (W, J) lookups with Cost.
- Loaded serially over a valid/ready stream. While loading, holds the job-assignment initiator in reset; releases it once the table is complete.
- Captures the initiator's final result (MinCost, MatchCount) when Valid fires, plus the elapsed cycle count.

---
 rtl/jam_cost_table.sv | 143 ++++++++++++++
 tb/tb_jam_cost_table.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jam_cost_table.sv
// Cost-matrix responder for the job-assignment initiator: serial 8x8 table load,
// zero-latency (W,J) lookup while serving, and capture of the initiator's result.
module jam_cost_table #(
   parameter int COST_W = 7,
   parameter int CYC_W  = 19
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic              load_valid,
   input  logic [COST_W-1:0] load_data,
   output logic              load_ready,
   input  logic [2:0]        W,
   input  logic [2:0]        J,
   output logic [COST_W-1:0] Cost,
   input  logic              Valid,
   input  logic [9:0]        MinCost,
   input  logic [3:0]        MatchCount,
   output logic              jam_rst,
   output logic              table_ready,
   output logic              done,
   output logic [9:0]        result_min,
   output logic [3:0]        result_cnt,
   output logic [12:0]       table_sum,
   output logic [CYC_W-1:0]  cycles
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_SERVE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [5:0]        ptr_q, ptr_d;
   logic              load_ready_q, load_ready_d;
   logic              table_ready_q, table_ready_d;
   logic              jam_rst_q, jam_rst_d;
   logic              done_q, done_d;
   logic [9:0]        result_min_q, result_min_d;
   logic [3:0]        result_cnt_q, result_cnt_d;
   logic [12:0]       table_sum_q, table_sum_d;
   logic [CYC_W-1:0]  cycles_q, cycles_d;
   logic              mem_we;

   logic [COST_W-1:0] mem [0:63];

   always_comb begin
      // NOTE: every always_comb output takes its hold value first so no path leaves it unassigned (no latch).
      state_d       = state_q;
      ptr_d         = ptr_q;
      load_ready_d  = load_ready_q;
      table_ready_d = table_ready_q;
      jam_rst_d     = jam_rst_q;
      done_d        = done_q;
      result_min_d  = result_min_q;
      result_cnt_d  = result_cnt_q;
      table_sum_d   = table_sum_q;
      cycles_d      = cycles_q;
      mem_we        = 1'b0;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d      = S_LOAD;
               ptr_d        = 6'd0;
               table_sum_d  = 13'd0;
               cycles_d     = '0;
               done_d       = 1'b0;
               load_ready_d = 1'b1;
            end
         end
         S_LOAD: begin
            if (load_valid && load_ready_q) begin
               mem_we      = 1'b1;
               ptr_d       = ptr_q + 6'd1;
               table_sum_d = table_sum_q + {{(13-COST_W){1'b0}}, load_data};
               if (ptr_q == 6'd63) begin
                  state_d       = S_SERVE;
                  load_ready_d  = 1'b0;
                  table_ready_d = 1'b1;
                  jam_rst_d     = 1'b0;
               end
            end
         end
         default: begin
            // Count includes the cycle on which Valid arrives.
            if (cycles_q != '1) cycles_d = cycles_q + 1'b1;
            if (Valid) begin
               state_d       = S_DONE;
               result_min_d  = MinCost;
               result_cnt_d  = MatchCount;
               done_d        = 1'b1;
               jam_rst_d     = 1'b1;
               table_ready_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= S_IDLE;
         ptr_q         <= 6'd0;
         load_ready_q  <= 1'b0;
         table_ready_q <= 1'b0;
         jam_rst_q     <= 1'b1;
         done_q        <= 1'b0;
         result_min_q  <= 10'd0;
         result_cnt_q  <= 4'd0;
         table_sum_q   <= 13'd0;
         cycles_q      <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         load_ready_q  <= load_ready_d;
         table_ready_q <= table_ready_d;
         jam_rst_q     <= jam_rst_d;
         done_q        <= done_d;
         result_min_q  <= result_min_d;
         result_cnt_q  <= result_cnt_d;
         table_sum_q   <= table_sum_d;
         cycles_q      <= cycles_d;
      end
   end

   // NOTE: storage has no reset; it is only served after a complete reload.
   always_ff @(posedge CLK) begin
      if (mem_we) mem[ptr_q] <= load_data;
   end

   // Combinational read: the initiator registers W/J and accumulates Cost on the next edge.
   assign Cost        = (state_q == S_SERVE) ? mem[{W, J}] : '0;
   assign load_ready  = load_ready_q;
   assign table_ready = table_ready_q;
   assign jam_rst     = jam_rst_q;
   assign done        = done_q;
   assign result_min  = result_min_q;
   assign result_cnt  = result_cnt_q;
   assign table_sum   = table_sum_q;
   assign cycles      = cycles_q;

endmodule

// File: tb/tb_jam_cost_table.sv
// Scoreboard bench for jam_cost_table: stimulus queues expected values, a negedge
// monitor pops and compares them against the selected DUT output.
module tb_jam_cost_table;

   localparam int COST_W = 7;
   localparam int CYC_W  = 19;

   localparam int SEL_LOAD_READY  = 0;
   localparam int SEL_TABLE_READY = 1;
   localparam int SEL_JAM_RST     = 2;
   localparam int SEL_DONE        = 3;
   localparam int SEL_RES_MIN     = 4;
   localparam int SEL_RES_CNT     = 5;
   localparam int SEL_SUM         = 6;
   localparam int SEL_CYCLES      = 7;
   localparam int SEL_COST        = 8;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   logic              CLK = 1'b0;
   logic              RST;
   logic              start;
   logic              load_valid;
   logic [COST_W-1:0] load_data;
   logic              load_ready;
   logic [2:0]        W;
   logic [2:0]        J;
   logic [COST_W-1:0] Cost;
   logic              Valid;
   logic [9:0]        MinCost;
   logic [3:0]        MatchCount;
   logic              jam_rst;
   logic              table_ready;
   logic              done;
   logic [9:0]        result_min;
   logic [3:0]        result_cnt;
   logic [12:0]       table_sum;
   logic [CYC_W-1:0]  cycles;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   jam_cost_table #(.COST_W(COST_W), .CYC_W(CYC_W)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
      .W(W), .J(J), .Cost(Cost),
      .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
      .jam_rst(jam_rst), .table_ready(table_ready), .done(done),
      .result_min(result_min), .result_cnt(result_cnt),
      .table_sum(table_sum), .cycles(cycles)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] get_sig(input int sel);
      case (sel)
         SEL_LOAD_READY:  return 32'(load_ready);
         SEL_TABLE_READY: return 32'(table_ready);
         SEL_JAM_RST:     return 32'(jam_rst);
         SEL_DONE:        return 32'(done);
         SEL_RES_MIN:     return 32'(result_min);
         SEL_RES_CNT:     return 32'(result_cnt);
         SEL_SUM:         return 32'(table_sum);
         SEL_CYCLES:      return 32'(cycles);
         default:         return 32'(Cost);
      endcase
   endfunction

   task automatic check(input string name, input int sel, input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.sel  = sel;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   // Monitor: compare every expectation queued during this clock-high phase.
   always @(negedge CLK) begin
      while (exp_q.size() > 0) begin
         automatic exp_t e = exp_q.pop_front();
         automatic logic [31:0] act = get_sig(e.sel);
         n_tests++;
         if (act !== e.exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Load entries with optional one-cycle gaps; value = (i*mul) % 128, or diag/100 pattern.
   task automatic load_table(input int mul, input bit gaps, input bit diag);
      for (int i = 0; i < 64; i++) begin
         load_valid = 1'b1;
         if (diag) load_data = ((i / 8) == (i % 8)) ? 7'd0 : 7'd100;
         else      load_data = COST_W'((i * mul) % 128);
         tick();
         if (gaps) begin
            load_valid = 1'b0;
            load_data  = 7'd99;
            tick();
         end
      end
      load_valid = 1'b0;
   endtask

   task automatic finish_serve(input logic [9:0] mc, input logic [3:0] cnt);
      Valid      = 1'b1;
      MinCost    = mc;
      MatchCount = cnt;
      tick();
      Valid = 1'b0;
   endtask

   initial begin
      int sum;
      int best;
      int nbest;
      int serve_n;

      RST = 1'b0; start = 1'b0; load_valid = 1'b0; load_data = '0;
      W = 3'd3; J = 3'd5; Valid = 1'b0; MinCost = '0; MatchCount = '0;
      #1;
      check("rst_load_ready", SEL_LOAD_READY, 0);
      check("rst_table_ready", SEL_TABLE_READY, 0);
      check("rst_jam_rst", SEL_JAM_RST, 1);
      check("rst_done", SEL_DONE, 0);
      check("rst_sum", SEL_SUM, 0);
      check("rst_cycles", SEL_CYCLES, 0);
      check("rst_cost_zero", SEL_COST, 0);
      tick();
      RST = 1'b1;
      tick();

      // Test 1: back-to-back load of 0..63
      do_start();
      check("load_ready_first", SEL_LOAD_READY, 1);
      check("cost_zero_load", SEL_COST, 0);
      for (int i = 0; i < 64; i++) begin
         load_valid = 1'b1;
         load_data  = COST_W'(i);
         tick();
         if (i == 62) check("not_ready_at_63", SEL_TABLE_READY, 0);
      end
      load_valid = 1'b0;
      check("t1_table_ready", SEL_TABLE_READY, 1);
      check("t1_jam_rst", SEL_JAM_RST, 0);
      check("t1_load_ready", SEL_LOAD_READY, 0);
      check("t1_sum", SEL_SUM, 2016);

      // Test 2 + start ignored in SERVE
      W = 3'd3; J = 3'd5;
      check("t2_cost_3_5", SEL_COST, 29);
      tick();
      W = 3'd7; J = 3'd7; start = 1'b1;
      check("t2_cost_7_7", SEL_COST, 63);
      tick();
      start = 1'b0;
      check("t6_start_serve_ready", SEL_TABLE_READY, 1);
      check("t6_start_serve_lr", SEL_LOAD_READY, 0);
      check("t6_cycles_count", SEL_CYCLES, 2);
      finish_serve(10'd5, 4'd2);
      check("t2_done", SEL_DONE, 1);
      check("t2_res_min", SEL_RES_MIN, 5);
      check("t2_res_cnt", SEL_RES_CNT, 2);
      check("t2_cycles", SEL_CYCLES, 3);
      check("t2_jam_rst", SEL_JAM_RST, 1);
      check("t2_cost_done", SEL_COST, 0);

      // Test 3: gapped load, junk data on idle cycles must be ignored
      do_start();
      check("t3_done_clr", SEL_DONE, 0);
      load_table(1, 1'b1, 1'b0);
      check("t3_sum", SEL_SUM, 2016);
      check("t3_table_ready", SEL_TABLE_READY, 1);
      W = 3'd0; J = 3'd1;
      check("t3_cost_0_1", SEL_COST, 1);
      tick();
      W = 3'd6; J = 3'd2;
      check("t3_cost_6_2", SEL_COST, 50);
      tick();
      finish_serve(10'd0, 4'd0);

      // Test 4: behavioural initiator over identity and shifted permutations
      do_start();
      load_table(0, 1'b0, 1'b1);
      check("t4_sum", SEL_SUM, 5600);
      serve_n = 0;
      best = 1 << 30;
      nbest = 0;
      for (int p = 0; p < 2; p++) begin
         sum = 0;
         for (int w = 0; w < 8; w++) begin
            W = 3'(w);
            J = 3'((w + p) % 8);
            @(negedge CLK);
            sum += int'(Cost);
            @(posedge CLK); #1;
            serve_n++;
         end
         if (sum < best) begin best = sum; nbest = 1; end
         else if (sum == best) nbest++;
      end
      finish_serve(10'(best), 4'(nbest));
      serve_n++;
      check("t4_done", SEL_DONE, 1);
      check("t4_res_min", SEL_RES_MIN, 0);
      check("t4_res_cnt", SEL_RES_CNT, 1);
      check("t4_jam_rst", SEL_JAM_RST, 1);
      check("t4_cycles", SEL_CYCLES, 32'(serve_n));

      // Test 5: reset mid-load, then full reload; Valid during LOAD ignored
      do_start();
      for (int i = 0; i < 30; i++) begin
         load_valid = 1'b1;
         load_data  = COST_W'(i);
         tick();
      end
      load_valid = 1'b0;
      RST = 1'b0;
      #1;
      check("t5_rst_lr", SEL_LOAD_READY, 0);
      check("t5_rst_jam", SEL_JAM_RST, 1);
      check("t5_rst_sum", SEL_SUM, 0);
      check("t5_rst_min", SEL_RES_MIN, 0);
      tick();
      RST = 1'b1;
      tick();
      do_start();
      Valid = 1'b1; MinCost = 10'd77; MatchCount = 4'd9;
      tick();
      Valid = 1'b0;
      check("t6_valid_load_done", SEL_DONE, 0);
      check("t6_valid_load_min", SEL_RES_MIN, 0);
      check("t6_valid_load_lr", SEL_LOAD_READY, 1);
      load_table(2, 1'b0, 1'b0);
      check("t5_sum", SEL_SUM, 4032);
      check("t5_table_ready", SEL_TABLE_READY, 1);
      W = 3'd5; J = 3'd0;
      check("t5_cost_5_0", SEL_COST, 80);
      tick();
      tick();

      if (exp_q.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: %0d pending, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
